// File: rtl/scan_sequencer.sv
// Band/column scan sequencer for the five-stage image filter chain (MED, GAU, SOB, NMS, HYS).
// Optional drain watchdog enabled by defining SCHED_DRAIN_TIMEOUT_EN.
module scan_sequencer #(
    parameter int IMG_DIM = 20,
    parameter int AW      = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          mod_readable,
    output logic [2:0]    stage,
    output logic          ksize5,
    output logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic          mod_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_valid,
    output logic          wb_req,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int CW = $clog2(IMG_DIM + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_DIM - 1);
    localparam logic [AW-1:0] DIM_A    = AW'(IMG_DIM);
    localparam logic [AW-1:0] TOTAL3   = AW'((IMG_DIM - 2) * (IMG_DIM - 2));
    localparam logic [AW-1:0] TOTAL5   = AW'((IMG_DIM - 4) * (IMG_DIM - 4));
    localparam logic [2:0]    ST_MED   = 3'd1;
    localparam logic [2:0]    ST_GAU   = 3'd2;
    localparam logic [2:0]    ST_HYS   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_SET_OP, S_PREP, S_SCAN, S_DRAIN, S_WB, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] band, col, wr_row, wr_col;
    logic [AW-1:0] wr_cnt;
    logic [CW-1:0] kmin1, half, last_band, last_wcol;
    logic [AW-1:0] total;
    logic          wr_full, accept, scan_go, timeout;

    // Kernel geometry follows the current stage: 5 rows for GAU, 3 otherwise.
    assign ksize5    = (stage == ST_GAU);
    assign kmin1     = ksize5 ? CW'(4) : CW'(2);
    assign half      = ksize5 ? CW'(2) : CW'(1);
    assign last_band = LAST_COL - kmin1;
    assign last_wcol = half + last_band;
    assign total     = ksize5 ? TOTAL5 : TOTAL3;

    assign wr_full = (wr_cnt == total);
    assign accept  = mod_readable && !wr_full && (state inside {S_SCAN, S_PREP, S_DRAIN});
    assign scan_go = (state == S_SCAN) && !stall;

    assign rd_addr = AW'(band) * DIM_A + AW'(col);
    assign wr_addr = AW'(wr_row) * DIM_A + AW'(wr_col);

`ifdef SCHED_DRAIN_TIMEOUT_EN
    logic [5:0] tmo_cnt;
    logic       err_q;

    // 64th idle drain cycle trips the watchdog; err shows up with the FSM already in IDLE.
    assign timeout = (state == S_DRAIN) && !wr_full && !accept && (tmo_cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state != S_DRAIN || accept)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 6'd1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        wb_req    = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        rd_valid  = scan_go;
        mod_en    = scan_go && (col >= kmin1);
        wr_valid  = accept;
        unique case (state)
            S_IDLE:   if (start) state_nxt = S_SET_OP;
            S_SET_OP: state_nxt = S_PREP;
            S_PREP:   state_nxt = S_SCAN;
            S_SCAN:
                if (scan_go && col == LAST_COL)
                    state_nxt = (band == last_band) ? S_DRAIN : S_PREP;
            S_DRAIN:
                if (wr_full)
                    state_nxt = (stage == ST_HYS) ? S_DONE : S_WB;
                else if (timeout)
                    state_nxt = S_IDLE;
            S_WB: begin
                wb_req    = 1'b1;
                state_nxt = S_SET_OP;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Every path back to IDLE (done, watchdog, idle hold) leaves all counters and stage at zero.
    always_ff @(posedge clk) begin
        if (reset || state_nxt == S_IDLE) begin
            stage  <= '0;
            band   <= '0;
            col    <= '0;
            wr_row <= '0;
            wr_col <= '0;
            wr_cnt <= '0;
        end else if (state == S_SET_OP) begin
            stage  <= stage + 3'd1;
            band   <= '0;
            col    <= '0;
            wr_cnt <= '0;
            // stage still holds the previous value here; the next one is GAU if this is MED.
            wr_row <= (stage == ST_MED) ? CW'(2) : CW'(1);
            wr_col <= (stage == ST_MED) ? CW'(2) : CW'(1);
        end else begin
            if (scan_go) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    if (band != last_band)
                        band <= band + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (accept) begin
                wr_cnt <= wr_cnt + AW'(1);
                if (wr_col == last_wcol) begin
                    wr_col <= half;
                    wr_row <= wr_row + CW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
        end
    end

endmodule
